// File: rtl/floatmul_pkg.sv
// Shared float32 types, constants and classification helpers for the
// floatmul block and its datapath.
package floatmul_pkg;

    typedef struct packed {
        logic        sign;
        logic [7:0]  exp;
        logic [22:0] mant;
    } float32_t;

    localparam int          FP_EXP_BIAS = 127;
    localparam logic [31:0] FP_QNAN     = 32'h7FC00000;
    localparam logic [7:0]  FP_INF_EXP  = 8'hFF;

    typedef enum logic [1:0] {COLLECT, MUL, NORM, OUT} state_t;
    typedef enum logic [1:0] {SP_NONE, SP_NAN, SP_INF, SP_ZERO} special_t;

    function automatic logic is_nan(input float32_t f);
        return (f.exp == FP_INF_EXP) && (f.mant != '0);
    endfunction

    function automatic logic is_inf(input float32_t f);
        return (f.exp == FP_INF_EXP) && (f.mant == '0);
    endfunction

    // Subnormals are treated as zero throughout (flush to zero).
    function automatic logic is_zero_or_sub(input float32_t f);
        return f.exp == 8'h00;
    endfunction

endpackage

// File: rtl/floatmul_core.sv
// Two-stage float32 multiply datapath: mantissa product and special-case
// classification, then normalize, round-to-nearest-even and saturate.
module floatmul_core
    import floatmul_pkg::*;
(
    input  logic     clk,
    input  logic     rst,
    input  logic     mul_en,
    input  float32_t a,
    input  float32_t b,
    output logic     res_vld,
    output float32_t res
);

    logic               vld_p1, vld_p2;
    logic               sign_p1;
    logic signed [9:0]  exp_p1;
    logic [47:0]        prod_p1;
    special_t           spec_p1;
    float32_t           res_p2;

    function automatic special_t special_sel(input float32_t x, input float32_t y);
        if (is_nan(x) || is_nan(y))
            return SP_NAN;
        if ((is_inf(x) && is_zero_or_sub(y)) || (is_inf(y) && is_zero_or_sub(x)))
            return SP_NAN;
        if (is_inf(x) || is_inf(y))
            return SP_INF;
        if (is_zero_or_sub(x) || is_zero_or_sub(y))
            return SP_ZERO;
        return SP_NONE;
    endfunction

    function automatic float32_t saturate(input logic s, input logic signed [9:0] ex,
                                          input logic [22:0] m, input special_t sp);
        float32_t r;
        r = '{sign: s, exp: ex[7:0], mant: m};
        case (sp)
            SP_NAN:  r = FP_QNAN;
            SP_INF:  r = '{sign: s, exp: FP_INF_EXP, mant: '0};
            SP_ZERO: r = '{sign: s, exp: '0, mant: '0};
            default: begin
                if (ex >= 10'sd255)
                    r = '{sign: s, exp: FP_INF_EXP, mant: '0};
                else if (ex <= 10'sd0)
                    r = '{sign: s, exp: '0, mant: '0};
            end
        endcase
        return r;
    endfunction

    function automatic float32_t round_norm(input logic s, input logic signed [9:0] e,
                                            input logic [47:0] p, input special_t sp);
        logic [22:0]       m;
        logic              g, st;
        logic [23:0]       mr;
        logic signed [9:0] ex;
        if (p[47]) begin
            m  = p[46:24];
            g  = p[23];
            st = |p[22:0];
            ex = e + 10'sd1;
        end else begin
            m  = p[45:23];
            g  = p[22];
            st = |p[21:0];
            ex = e;
        end
        mr = {1'b0, m} + 24'(g & (st | m[0]));
        // All-ones fraction rounding up wraps to 1.0 of the next binade.
        if (mr[23])
            ex = ex + 10'sd1;
        return saturate(s, ex, mr[22:0], sp);
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_p1 <= 1'b0;
            vld_p2 <= 1'b0;
        end else begin
            vld_p1 <= mul_en;
            vld_p2 <= vld_p1;
        end
    end

    // p1: sign, biased exponent sum and 24x24 product with hidden ones
    always_ff @(posedge clk) begin
        if (mul_en) begin
            sign_p1 <= a.sign ^ b.sign;
            exp_p1  <= $signed({2'b00, a.exp}) + $signed({2'b00, b.exp}) - 10'(FP_EXP_BIAS);
            prod_p1 <= 48'({1'b1, a.mant}) * 48'({1'b1, b.mant});
            spec_p1 <= special_sel(a, b);
        end
    end

    // p2: normalized, rounded and saturated result
    always_ff @(posedge clk) begin
        if (vld_p1)
            res_p2 <= round_norm(sign_p1, exp_p1, prod_p1, spec_p1);
    end

    assign res_vld = vld_p2;
    assign res     = res_p2;

endmodule

// File: rtl/floatmul.sv
// float32 multiplier wrapper: operand holding registers, control FSM and the
// A/B/O valid-ready handshakes around floatmul_core.
module floatmul
    import floatmul_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    output logic        busy,
    input  logic        a_valid,
    input  logic [31:0] a_data,
    output logic        a_ready,
    input  logic        b_valid,
    input  logic [31:0] b_data,
    output logic        b_ready,
    output logic        o_valid,
    output logic [31:0] o_data,
    input  logic        o_ready
);

    state_t   state, state_nxt;
    float32_t a_p0, b_p0;
    logic     a_full, b_full;
    logic     mul_en;
    logic     res_vld;
    float32_t res;

    assign a_ready = !a_full && (state == COLLECT);
    assign b_ready = !b_full && (state == COLLECT);
    assign o_valid = (state == OUT);
    assign busy    = a_full || b_full || (state != COLLECT);

    always_comb begin
        state_nxt = state;
        mul_en    = 1'b0;
        case (state)
            COLLECT: if (a_full && b_full) begin
                state_nxt = MUL;
                mul_en    = 1'b1;
            end
            MUL:     state_nxt = NORM;
            NORM:    if (res_vld) state_nxt = OUT;
            OUT:     if (o_ready) state_nxt = COLLECT;
            default: state_nxt = COLLECT;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= COLLECT;
            a_full <= 1'b0;
            b_full <= 1'b0;
            o_data <= '0;
        end else begin
            state <= state_nxt;
            if (mul_en)
                a_full <= 1'b0;
            else if (a_valid && a_ready)
                a_full <= 1'b1;
            if (mul_en)
                b_full <= 1'b0;
            else if (b_valid && b_ready)
                b_full <= 1'b1;
            if ((state == NORM) && res_vld)
                o_data <= res;
        end
    end

    // p0: operand holding registers
    always_ff @(posedge clk) begin
        if (a_valid && a_ready)
            a_p0 <= a_data;
        if (b_valid && b_ready)
            b_p0 <= b_data;
    end

    floatmul_core u_core (
        .clk     (clk),
        .rst     (rst),
        .mul_en  (mul_en),
        .a       (a_p0),
        .b       (b_p0),
        .res_vld (res_vld),
        .res     (res)
    );

endmodule

// File: tb/tb_floatmul.sv
// Self-checking bench for floatmul: directed vectors, ordering, backpressure,
// reset mid-operation and randomized operands against an arithmetic model.
module tb_floatmul;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        busy;
    logic        a_valid = 1'b0;
    logic [31:0] a_data = '0;
    logic        a_ready;
    logic        b_valid = 1'b0;
    logic [31:0] b_data = '0;
    logic        b_ready;
    logic        o_valid;
    logic [31:0] o_data;
    logic        o_ready = 1'b0;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    floatmul dut (
        .clk     (clk),
        .rst     (rst),
        .busy    (busy),
        .a_valid (a_valid),
        .a_data  (a_data),
        .a_ready (a_ready),
        .b_valid (b_valid),
        .b_data  (b_data),
        .b_ready (b_ready),
        .o_valid (o_valid),
        .o_data  (o_data),
        .o_ready (o_ready)
    );

    // Reference: exact integer product, then nearest-even rounding by remainder.
    function automatic logic [31:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
        logic s;
        int ea, eb, e, sh;
        bit nan_a, nan_b, inf_a, inf_b, zer_a, zer_b;
        longint unsigned ma, mb, p, q, r, half;
        s  = a[31] ^ b[31];
        ea = int'(a[30:23]);
        eb = int'(b[30:23]);
        nan_a = (ea == 255) && (a[22:0] != 0);
        nan_b = (eb == 255) && (b[22:0] != 0);
        inf_a = (ea == 255) && (a[22:0] == 0);
        inf_b = (eb == 255) && (b[22:0] == 0);
        zer_a = (ea == 0);
        zer_b = (eb == 0);
        if (nan_a || nan_b) return 32'h7FC00000;
        if ((inf_a && zer_b) || (inf_b && zer_a)) return 32'h7FC00000;
        if (inf_a || inf_b) return {s, 8'hFF, 23'd0};
        if (zer_a || zer_b) return {s, 31'd0};
        ma = 64'd8388608 + longint'(a[22:0]);
        mb = 64'd8388608 + longint'(b[22:0]);
        p  = ma * mb;
        e  = ea + eb - 127;
        sh = 23;
        if (p >= (64'd1 << 47)) begin
            sh = 24;
            e  = e + 1;
        end
        q    = p >> sh;
        r    = p - (q << sh);
        half = 64'd1 << (sh - 1);
        if (r > half || (r == half && q[0])) q = q + 1;
        if (q == (64'd1 << 24)) begin
            q = q >> 1;
            e = e + 1;
        end
        if (e >= 255) return {s, 8'hFF, 23'd0};
        if (e <= 0) return {s, 31'd0};
        return {s, e[7:0], q[22:0]};
    endfunction

    function automatic logic [31:0] rand_float();
        logic [31:0] v;
        int k;
        k = $urandom_range(0, 9);
        v = $urandom;
        case (k)
            0: case ($urandom_range(0, 5))
                   0: v = 32'h00000000;
                   1: v = 32'h80000000;
                   2: v = 32'h7F800000;
                   3: v = 32'hFF800000;
                   4: v = 32'h7FC00001;
                   default: v = {v[31], 8'h00, v[22:0]};
               endcase
            1: ;
            default: v[30:23] = 8'($urandom_range(60, 195));
        endcase
        return v;
    endfunction

    // Stimulus driver only: presents A after ga cycles and B after gb cycles,
    // waits for the product and accepts it after ready_dly cycles.
    task automatic do_op(input logic [31:0] a, input logic [31:0] b, input int ga,
                         input int gb, input int ready_dly, output logic [31:0] got,
                         output int lat, output bit tmo);
        bit a_done = 0, b_done = 0, ar, br;
        int c = 0;
        tmo = 0;
        lat = 0;
        got = '0;
        while (!(a_done && b_done) && c < 64) begin
            a_valid = !a_done && (c >= ga);
            a_data  = a;
            b_valid = !b_done && (c >= gb);
            b_data  = b;
            ar = a_valid && a_ready;
            br = b_valid && b_ready;
            @(posedge clk); #1;
            a_done = a_done | ar;
            b_done = b_done | br;
            c++;
        end
        a_valid = 1'b0;
        b_valid = 1'b0;
        if (!(a_done && b_done)) begin
            tmo = 1;
            return;
        end
        while (!o_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!o_valid) begin
            tmo = 1;
            return;
        end
        got = o_data;
        repeat (ready_dly) begin @(posedge clk); #1; end
        o_ready = 1'b1;
        @(posedge clk); #1;
        o_ready = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        checks++; if (a_ready !== 1'b1) begin errors++; $display("FAIL reset_a_ready got=%b exp=1", a_ready); end
        checks++; if (b_ready !== 1'b1) begin errors++; $display("FAIL reset_b_ready got=%b exp=1", b_ready); end
        checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL reset_o_valid got=%b exp=0", o_valid); end
        checks++; if (o_data !== 32'h0) begin errors++; $display("FAIL reset_o_data got=%h exp=0", o_data); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_directed();
        logic [31:0] va [8] = '{32'h40000000, 32'hBF800000, 32'h00000000, 32'h7F800000,
                                32'h7F800000, 32'h7F7FFFFF, 32'h00800000, 32'h3F800001};
        logic [31:0] vb [8] = '{32'h40400000, 32'h3F000000, 32'hC0000000, 32'h00000000,
                                32'hC0000000, 32'h40000000, 32'h3F000000, 32'h3F800001};
        logic [31:0] ve [8] = '{32'h40C00000, 32'hBF000000, 32'h80000000, 32'h7FC00000,
                                32'hFF800000, 32'h7F800000, 32'h00000000, 32'h3F800002};
        logic [31:0] got;
        int lat;
        bit tmo;
        for (int i = 0; i < 8; i++) begin
            do_op(va[i], vb[i], 0, 0, 0, got, lat, tmo);
            checks++;
            if (tmo || got !== ve[i]) begin
                errors++;
                $display("FAIL directed_%0d %h x %h got=%h exp=%h timeout=%0d", i, va[i], vb[i], got, ve[i], tmo);
            end
            checks++;
            if (lat != 3) begin errors++; $display("FAIL latency_%0d got=%0d exp=3", i, lat); end
        end
    endtask

    task automatic test_order();
        int lat = 0;
        bit busy_ok = 1;
        a_valid = 1'b1; a_data = 32'h3FC00000;
        @(posedge clk); #1;
        a_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++; if (a_ready !== 1'b0) begin errors++; $display("FAIL order_a_ready_%0d got=%b exp=0", i, a_ready); end
            checks++; if (b_ready !== 1'b1) begin errors++; $display("FAIL order_b_ready_%0d got=%b exp=1", i, b_ready); end
            checks++; if (busy !== 1'b1) begin errors++; $display("FAIL order_busy_%0d got=%b exp=1", i, busy); end
            if (i == 2) begin b_valid = 1'b1; b_data = 32'h3FC00000; end
            @(posedge clk); #1;
        end
        b_valid = 1'b0;
        while (!o_valid && lat < 20) begin
            if (busy !== 1'b1) busy_ok = 0;
            @(posedge clk); #1;
            lat++;
        end
        checks++; if (!busy_ok) begin errors++; $display("FAIL order_busy_inflight got=0 exp=1"); end
        checks++; if (lat != 3) begin errors++; $display("FAIL order_latency got=%0d exp=3", lat); end
        checks++; if (o_data !== 32'h40100000) begin errors++; $display("FAIL order_result got=%h exp=40100000", o_data); end
        o_ready = 1'b1;
        @(posedge clk); #1;
        o_ready = 1'b0;
        checks++; if (o_valid !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL order_after_accept o_valid=%b busy=%b exp 0/0", o_valid, busy);
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] got;
        int lat = 0;
        bit tmo;
        a_valid = 1'b1; a_data = 32'h40000000;
        b_valid = 1'b1; b_data = 32'h40400000;
        @(posedge clk); #1;
        a_valid = 1'b0; b_valid = 1'b0;
        while (!o_valid && lat < 20) begin @(posedge clk); #1; lat++; end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (o_valid !== 1'b1 || o_data !== 32'h40C00000 || a_ready !== 1'b0 || b_ready !== 1'b0 || busy !== 1'b1) begin
                errors++;
                $display("FAIL hold_%0d o_valid=%b o_data=%h a_ready=%b b_ready=%b busy=%b exp 1/40c00000/0/0/1",
                         i, o_valid, o_data, a_ready, b_ready, busy);
            end
            @(posedge clk); #1;
        end
        o_ready = 1'b1;
        @(posedge clk); #1;
        o_ready = 1'b0;
        // Result pending, then reset pulled asynchronously between edges.
        a_valid = 1'b1; a_data = 32'h3FC00000;
        b_valid = 1'b1; b_data = 32'h3FC00000;
        @(posedge clk); #1;
        a_valid = 1'b0; b_valid = 1'b0;
        lat = 0;
        while (!o_valid && lat < 20) begin @(posedge clk); #1; lat++; end
        checks++; if (o_valid !== 1'b1) begin errors++; $display("FAIL pre_reset_o_valid got=%b exp=1", o_valid); end
        #2 rst = 1'b0;
        #1;
        checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL midreset_o_valid got=%b exp=0", o_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midreset_busy got=%b exp=0", busy); end
        checks++; if (a_ready !== 1'b1 || b_ready !== 1'b1) begin
            errors++; $display("FAIL midreset_ready a=%b b=%b exp 1/1", a_ready, b_ready);
        end
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        do_op(32'h40000000, 32'h40400000, 0, 0, 0, got, lat, tmo);
        checks++;
        if (tmo || got !== 32'h40C00000) begin
            errors++; $display("FAIL post_reset_op got=%h exp=40c00000 timeout=%0d", got, tmo);
        end
    endtask

    task automatic test_random();
        logic [31:0] a, b, exp_v, got;
        int lat;
        bit tmo;
        for (int i = 0; i < 300; i++) begin
            a = rand_float();
            b = rand_float();
            exp_v = ref_mul(a, b);
            do_op(a, b, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3), got, lat, tmo);
            checks++;
            if (tmo || got !== exp_v || lat != 3) begin
                errors++;
                $display("FAIL random_%0d %h x %h got=%h exp=%h lat=%0d timeout=%0d", i, a, b, got, exp_v, lat, tmo);
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_directed();
        test_order();
        test_backpressure();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
